multi_queue: RTL and testbench

MULTI_QUEUE -- requirements
Module: multi_queue

---
 rtl/multi_queue_pkg.sv | 17 +
 rtl/multi_queue_if.sv | 30 +++
 rtl/multi_queue_ring_ptr.sv | 22 ++
 rtl/multi_queue.sv | 96 +++++++++
 tb/tb_multi_queue.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_queue_pkg.sv
// rtl/multi_queue_pkg.sv - shared entry type and modular pointer helpers for multi_queue
package multi_queue_pkg;

  typedef logic [31:0] gpreg;

  // Modular add for ring pointers; inc never exceeds depth, so one subtract covers the wrap.
  function automatic int ptr_add(int ptr, int inc, int depth);
    int sum;
    sum = ptr + inc;
    return (sum >= depth) ? sum - depth : sum;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_queue_if.sv
// rtl/multi_queue_if.sv - multi-lane enqueue/dequeue handshake bundle for multi_queue
interface multi_queue_if
  import multi_queue_pkg::*;
#(
  parameter type Data  = gpreg,
  parameter int  DEPTH = 8,
  parameter int  ENQ_W = 2,
  parameter int  DEQ_W = 2
) ();

  logic                         flush;
  Data                          enq_data [ENQ_W];
  logic [$clog2(ENQ_W+1)-1:0]   enq_cnt;
  logic [$clog2(ENQ_W+1)-1:0]   enq_free;
  Data                          deq_data [DEQ_W];
  logic [$clog2(DEQ_W+1)-1:0]   deq_avail;
  logic [$clog2(DEQ_W+1)-1:0]   deq_cnt;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output flush, enq_data, enq_cnt, deq_cnt,
    input  enq_free, deq_data, deq_avail, count
  );

  modport slave (
    input  flush, enq_data, enq_cnt, deq_cnt,
    output enq_free, deq_data, deq_avail, count
  );

endinterface

// File: rtl/multi_queue_ring_ptr.sv
// rtl/multi_queue_ring_ptr.sv - ring_ptr: mod-DEPTH pointer register with variable increment
module ring_ptr
  import multi_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [IW-1:0] inc,
  output logic [PW-1:0] ptr
);

  // Advance by inc with explicit wrap so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst || clr) ptr <= '0;
    else            ptr <= PW'(ptr_add(int'(ptr), int'(inc), DEPTH));
  end

endmodule

// File: rtl/multi_queue.sv
// rtl/multi_queue.sv - multi-lane queue top; define MULTI_QUEUE_BYPASS_EN for enqueue-to-dequeue bypass
module multi_queue
  import multi_queue_pkg::*;
#(
  parameter type Data  = gpreg,
  parameter int  DEPTH = 8,
  parameter int  ENQ_W = 2,
  parameter int  DEQ_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  multi_queue_if.slave q
);

  localparam int EW   = $clog2(ENQ_W + 1);
  localparam int DW   = $clog2(DEQ_W + 1);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXW = (ENQ_W > DEQ_W) ? ENQ_W : DEQ_W;
  localparam int IW   = $clog2(MAXW + 1);

  Data           store [DEPTH];
  logic [CW-1:0] count_q;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [IW-1:0] head_inc;
  logic [IW-1:0] tail_inc;

  int cnt;
  int room;
  int acc;
  int avail;
  int tak;
  int byp;

  // Lane arithmetic: acceptance uses registered occupancy only; byp counts arrivals consumed on arrival.
  always_comb begin
    cnt   = int'(count_q);
    room  = imin(DEPTH - cnt, ENQ_W);
    acc   = imin(int'(q.enq_cnt), room);
`ifdef MULTI_QUEUE_BYPASS_EN
    avail = imin(cnt + acc, DEQ_W);
`else
    avail = imin(cnt, DEQ_W);
`endif
    tak      = imin(int'(q.deq_cnt), avail);
    byp      = (tak > cnt) ? tak - cnt : 0;
    head_inc = IW'(tak - byp);
    tail_inc = IW'(acc - byp);

    q.enq_free  = EW'(room);
    q.deq_avail = DW'(avail);
    q.count     = count_q;
    for (int i = 0; i < DEQ_W; i++) begin
      q.deq_data[i] = store[PW'(ptr_add(int'(head), i, DEPTH))];
`ifdef MULTI_QUEUE_BYPASS_EN
      for (int j = 0; j < ENQ_W; j++) begin
        if (i >= cnt && i - cnt == j) q.deq_data[i] = q.enq_data[j];
      end
`endif
    end
  end

  // Write only the accepted lanes that were not already handed straight to the consumer.
  always_ff @(posedge clk) begin
    if (!rst && !q.flush) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (i >= byp && i < acc)
          store[PW'(ptr_add(int'(tail), i - byp, DEPTH))] <= q.enq_data[i];
      end
    end
  end

  // Occupancy lives in its own register; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || q.flush) count_q <= '0;
    else                count_q <= CW'(cnt + acc - tak);
  end

  ring_ptr #(.DEPTH(DEPTH), .PW(PW), .IW(IW)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (q.flush),
    .inc (head_inc),
    .ptr (head)
  );

  ring_ptr #(.DEPTH(DEPTH), .PW(PW), .IW(IW)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (q.flush),
    .inc (tail_inc),
    .ptr (tail)
  );

endmodule

// File: tb/tb_multi_queue.sv
// tb/tb_multi_queue.sv - self-checking bench for multi_queue (DEPTH 8 and 5); honours MULTI_QUEUE_BYPASS_EN
module tb_multi_queue;
  import multi_queue_pkg::*;

`ifdef MULTI_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_queue_if #(.Data(gpreg), .DEPTH(8), .ENQ_W(2), .DEQ_W(2)) if8 ();
  multi_queue_if #(.Data(gpreg), .DEPTH(5), .ENQ_W(2), .DEQ_W(2)) if5 ();

  multi_queue #(.Data(gpreg), .DEPTH(8), .ENQ_W(2), .DEQ_W(2)) u8 (
    .clk (clk),
    .rst (rst),
    .q   (if8)
  );

  multi_queue #(.Data(gpreg), .DEPTH(5), .ENQ_W(2), .DEQ_W(2)) u5 (
    .clk (clk),
    .rst (rst),
    .q   (if5)
  );

  typedef struct {
    bit fl;
    int ec;
    int dc;
    int x_count;
    int x_free;
    int x_avail_nb;
    int x_avail_bp;
  } vec_t;

  vec_t tbl [11];

  int   total = 0;
  int   bad   = 0;

  int   st_fl [2];
  int   st_ec [2];
  int   st_dc [2];
  gpreg st_d  [2][2];

  int   ob_free  [2];
  int   ob_avail [2];
  int   ob_count [2];
  gpreg ob_d     [2][2];
  int   mx_tak   [2];

  gpreg mem [2][32768];
  int   mrd [2];
  int   mwr [2];

  gpreg nextv = 0;

  function automatic int dep(int k);
    return (k == 0) ? 8 : 5;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_idle(int k);
    st_fl[k] = 0;
    st_ec[k] = 0;
    st_dc[k] = 0;
    st_d[k][0] = '0;
    st_d[k][1] = '0;
  endtask

  task automatic drive();
    if8.flush       = (st_fl[0] != 0);
    if8.enq_cnt     = 2'(st_ec[0]);
    if8.deq_cnt     = 2'(st_dc[0]);
    if8.enq_data[0] = st_d[0][0];
    if8.enq_data[1] = st_d[0][1];
    if5.flush       = (st_fl[1] != 0);
    if5.enq_cnt     = 2'(st_ec[1]);
    if5.deq_cnt     = 2'(st_dc[1]);
    if5.enq_data[0] = st_d[1][0];
    if5.enq_data[1] = st_d[1][1];
  endtask

  task automatic sample();
    ob_free[0]  = int'(if8.enq_free);
    ob_avail[0] = int'(if8.deq_avail);
    ob_count[0] = int'(if8.count);
    ob_d[0][0]  = if8.deq_data[0];
    ob_d[0][1]  = if8.deq_data[1];
    ob_free[1]  = int'(if5.enq_free);
    ob_avail[1] = int'(if5.deq_avail);
    ob_count[1] = int'(if5.count);
    ob_d[1][0]  = if5.deq_data[0];
    ob_d[1][1]  = if5.deq_data[1];
  endtask

  // Reference queue: entries live at absolute sequence numbers mrd..mwr-1.
  task automatic model_step(int k);
    int   sz;
    int   ef;
    int   acc;
    int   av;
    int   tak;
    gpreg xd;
    sz  = mwr[k] - mrd[k];
    ef  = imin(dep(k) - sz, 2);
    acc = imin(st_ec[k], ef);
    av  = BYP ? imin(sz + acc, 2) : imin(sz, 2);
    tak = imin(st_dc[k], av);
    chk($sformatf("count[q%0d]", k), ob_count[k], sz);
    chk($sformatf("enq_free[q%0d]", k), ob_free[k], ef);
    chk($sformatf("deq_avail[q%0d]", k), ob_avail[k], av);
    for (int i = 0; i < av; i++) begin
      xd = (i < sz) ? mem[k][mrd[k] + i] : st_d[k][i - sz];
      chk($sformatf("deq_data[q%0d][%0d]", k, i), int'(ob_d[k][i]), int'(xd));
    end
    mx_tak[k] = tak;
    if (st_fl[k] != 0) begin
      mrd[k] = mwr[k];
    end else begin
      for (int i = 0; i < acc; i++) mem[k][mwr[k] + i] = st_d[k][i];
      mwr[k] = mwr[k] + acc;
      mrd[k] = mrd[k] + tak;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    sample();
    model_step(0);
    model_step(1);
    @(posedge clk);
  endtask

  // Reset is held while flush and enqueues are offered; reset must discard them.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st_fl[k] = 1;
      st_ec[k] = 2;
      st_dc[k] = 1;
      st_d[k][0] = 32'hdead_0000;
      st_d[k][1] = 32'hdead_0001;
    end
    drive();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_idle(0);
    set_idle(1);
    drive();
    for (int k = 0; k < 2; k++) mrd[k] = mwr[k];
  endtask

  int last;

  initial begin
    rst = 1'b1;
    set_idle(0);
    set_idle(1);
    drive();
    mrd[0] = 0; mwr[0] = 0;
    mrd[1] = 0; mwr[1] = 0;

    //            fl ec dc cnt free nb bp
    tbl[0]  = '{0, 2, 0, 0, 2, 0, 2};
    tbl[1]  = '{0, 2, 0, 2, 2, 2, 2};
    tbl[2]  = '{0, 2, 0, 4, 2, 2, 2};
    tbl[3]  = '{0, 2, 0, 6, 2, 2, 2};
    tbl[4]  = '{0, 2, 0, 8, 0, 2, 2};
    tbl[5]  = '{0, 2, 2, 8, 0, 2, 2};
    tbl[6]  = '{0, 0, 0, 6, 2, 2, 2};
    tbl[7]  = '{0, 0, 2, 6, 2, 2, 2};
    tbl[8]  = '{0, 0, 1, 4, 2, 2, 2};
    tbl[9]  = '{1, 2, 1, 3, 2, 2, 2};
    tbl[10] = '{0, 0, 0, 0, 2, 0, 0};

    repeat (2) @(posedge clk);
    do_reset();

    // Directed table on the depth-8 queue: fill, full boundary, full enq+deq, flush.
    for (int r = 0; r < 11; r++) begin
      set_idle(1);
      st_fl[0] = int'(tbl[r].fl);
      st_ec[0] = tbl[r].ec;
      st_dc[0] = tbl[r].dc;
      st_d[0][0] = nextv;
      st_d[0][1] = nextv + 1;
      nextv = nextv + 2;
      cycle();
      chk($sformatf("tbl%0d.count", r), ob_count[0], tbl[r].x_count);
      chk($sformatf("tbl%0d.enq_free", r), ob_free[0], tbl[r].x_free);
      chk($sformatf("tbl%0d.deq_avail", r), ob_avail[0],
          BYP ? tbl[r].x_avail_bp : tbl[r].x_avail_nb);
    end

    // Depth-5 queue: alternating enq 2 / deq 2 with ascending values.
    last = -1;
    for (int c = 0; c < 20; c++) begin
      set_idle(0);
      set_idle(1);
      if ((c % 2) == 0) begin
        st_ec[1] = 2;
        st_d[1][0] = nextv;
        st_d[1][1] = nextv + 1;
        nextv = nextv + 2;
      end else begin
        st_dc[1] = 2;
      end
      cycle();
      chk("q5.count_le_depth", (ob_count[1] <= 5) ? 1 : 0, 1);
      for (int i = 0; i < mx_tak[1]; i++) begin
        chk("q5.ascending", (int'(ob_d[1][i]) > last) ? 1 : 0, 1);
        last = int'(ob_d[1][i]);
      end
    end

`ifdef MULTI_QUEUE_BYPASS_EN
    // Bypass: empty queue, two arrive, one taken in the same cycle.
    set_idle(0);
    set_idle(1);
    st_ec[0] = 2;
    st_dc[0] = 1;
    st_d[0][0] = 32'h0000_00a1;
    st_d[0][1] = 32'h0000_00b2;
    cycle();
    chk("byp.same_cycle_a", int'(ob_d[0][0]), 32'h0000_00a1);
    set_idle(0);
    cycle();
    chk("byp.count_after", ob_count[0], 1);
    chk("byp.next_b", int'(ob_d[0][0]), 32'h0000_00b2);
    st_dc[0] = 1;
    cycle();
`endif

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++) begin
        st_fl[k] = ($urandom_range(0, 63) == 0) ? 1 : 0;
        if (((c / 300) % 2) == 0) begin
          st_ec[k] = $urandom_range(1, 2);
          st_dc[k] = $urandom_range(0, 1);
        end else begin
          st_ec[k] = $urandom_range(0, 1);
          st_dc[k] = $urandom_range(1, 2);
        end
        st_d[k][0] = $urandom();
        st_d[k][1] = $urandom();
      end
      cycle();
    end

    // Reset in the middle of traffic drops everything.
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        set_idle(k);
        st_ec[k] = 2;
        st_d[k][0] = nextv;
        st_d[k][1] = nextv + 1;
        nextv = nextv + 2;
      end
      cycle();
    end
    do_reset();
    cycle();
    chk("post_reset.count8", ob_count[0], 0);
    chk("post_reset.count5", ob_count[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
